piece_spawner: RTL

Producer side of the falling-piece interface: generates each new tetromino's 4×4 occupancy mask and anchor position and hands it to the game controller, which feeds the same `float`/`pos_y` pair to the game-over check and collision logic. Piece selection uses a 16-bit LFSR with a 7-bag randomizer. One piece is always held as a preview. The block accepts a one-cycle spawn request and answers with a one-cycle valid pulse.

---
 rtl/tetris_pkg.sv | 60 ++++++
 rtl/piece_spawner_lfsr16.sv | 34 +++
 rtl/piece_spawner.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece codes, board height, spawn masks and the
// FSM state type used by the spawner.
package tetris_pkg;

    localparam logic [2:0] PIECE_I = 3'd0;
    localparam logic [2:0] PIECE_O = 3'd1;
    localparam logic [2:0] PIECE_T = 3'd2;
    localparam logic [2:0] PIECE_S = 3'd3;
    localparam logic [2:0] PIECE_Z = 3'd4;
    localparam logic [2:0] PIECE_J = 3'd5;
    localparam logic [2:0] PIECE_L = 3'd6;

    localparam int BOARD_VISIBLE_ROWS = 20;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Masks are written index 0 first (leftmost), so bits 12..15 are the top row.
    localparam logic [0:15] MASK_I = 16'b0000_0000_0000_1111;
    localparam logic [0:15] MASK_O = 16'b0000_0000_0110_0110;
    localparam logic [0:15] MASK_T = 16'b0000_0000_1110_0100;
    localparam logic [0:15] MASK_S = 16'b0000_0000_1100_0110;
    localparam logic [0:15] MASK_Z = 16'b0000_0000_0110_1100;
    localparam logic [0:15] MASK_J = 16'b0000_0000_1110_1000;
    localparam logic [0:15] MASK_L = 16'b0000_0000_1110_0010;

    typedef enum logic [1:0] {
        ST_DRAW  = 2'd0,
        ST_READY = 2'd1,
        ST_EMIT  = 2'd2
    } spawn_state_e;

    function automatic logic [0:15] spawn_mask(input logic [2:0] code);
        logic [0:15] m;
        case (code)
            PIECE_I: m = MASK_I;
            PIECE_O: m = MASK_O;
            PIECE_T: m = MASK_T;
            PIECE_S: m = MASK_S;
            PIECE_Z: m = MASK_Z;
            PIECE_J: m = MASK_J;
            PIECE_L: m = MASK_L;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] lowest_unused(input logic [6:0] used);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!used[i]) begin
                code = 3'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/piece_spawner_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400); advances every cycle unless loaded.
// A zero load value is replaced by the reset seed so the register never locks up.
module lfsr16
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED_RST = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] q_r;
    logic [15:0] shift_s;

    assign shift_s = {1'b0, q_r[15:1]};
    assign q       = q_r;

    // LFSR state: reset seed, explicit load, or one Galois step
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= SEED_RST;
        end else if (load) begin
            q_r <= (load_val == 16'h0000) ? SEED_RST : load_val;
        end else if (q_r[0]) begin
            q_r <= shift_s ^ LFSR_TAPS;
        end else begin
            q_r <= shift_s;
        end
    end

endmodule

// File: rtl/piece_spawner.sv
// Tetromino spawner: keeps one preview piece drawn from an LFSR and emits it as a
// one-cycle pulse on request. Define PIECE_BAG_EN for the 7-bag randomizer.
module piece_spawner
    import tetris_pkg::*;
#(
    parameter int          SPAWN_X   = 3,
    parameter int          SPAWN_Y   = 19,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED_RST  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        spawn_valid,
    output logic [0:15] float,
    output logic [3:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [2:0]  piece_type,
    output logic [2:0]  next_type,
    output logic        ready
);

    localparam int            TRY_W    = (MAX_TRIES > 2) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    spawn_state_e     state_r, state_next_s;
    logic [TRY_W-1:0] tries_r, tries_next_s;
    logic             pending_r, pending_next_s;
    logic [2:0]       next_type_r, next_type_next_s;
    logic [2:0]       piece_type_r, piece_type_next_s;
    logic [0:15]      float_r, float_next_s;
    logic [3:0]       pos_x_r, pos_x_next_s;
    logic [4:0]       pos_y_r, pos_y_next_s;
    logic             spawn_valid_r;
    logic             ready_r;
    logic [2:0]       pick_s;
    logic             pick_ok_s;
    logic [15:0]      lfsr_q_s;
    logic [12:0]      lfsr_unused_s;
    logic [2:0]       cand_s;

    lfsr16 #(.SEED_RST(SEED_RST)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed),
        .q        (lfsr_q_s)
    );

    assign cand_s        = lfsr_q_s[2:0];
    assign lfsr_unused_s = lfsr_q_s[15:3];

`ifdef PIECE_BAG_EN
    logic [6:0] used_r, used_next_s, used_set_s;
    logic [7:0] used8_s;

    // Code 7 is folded in as permanently used so it can never be accepted
    assign used8_s = {1'b1, used_r};
`endif

    // Next-state, preview draw and spawn output selection
    always_comb begin
        state_next_s      = state_r;
        tries_next_s      = tries_r;
        pending_next_s    = pending_r;
        next_type_next_s  = next_type_r;
        piece_type_next_s = piece_type_r;
        float_next_s      = float_r;
        pos_x_next_s      = pos_x_r;
        pos_y_next_s      = pos_y_r;
        pick_s            = 3'd0;
        pick_ok_s         = 1'b0;
`ifdef PIECE_BAG_EN
        used_next_s       = used_r;
        used_set_s        = 7'd0;
`endif
        case (state_r)
            ST_DRAW: begin
                pending_next_s = pending_r | spawn_req;
`ifdef PIECE_BAG_EN
                if (!used8_s[cand_s]) begin
                    pick_s    = cand_s;
                    pick_ok_s = 1'b1;
                end else if (tries_r == LAST_TRY) begin
                    pick_s    = lowest_unused(used_r);
                    pick_ok_s = 1'b1;
                end else begin
                    pick_ok_s = 1'b0;
                end
`else
                if (cand_s != 3'd7) begin
                    pick_s    = cand_s;
                    pick_ok_s = 1'b1;
                end else if (tries_r == LAST_TRY) begin
                    pick_s    = PIECE_I;
                    pick_ok_s = 1'b1;
                end else begin
                    pick_ok_s = 1'b0;
                end
`endif
                if (pick_ok_s) begin
                    next_type_next_s = pick_s;
                    state_next_s     = ST_READY;
`ifdef PIECE_BAG_EN
                    // Completing the bag empties it in the same cycle
                    used_set_s = used_r | (7'd1 << pick_s);
                    if (used_set_s == 7'h7F) begin
                        used_next_s = 7'd0;
                    end else begin
                        used_next_s = used_set_s;
                    end
`endif
                end else begin
                    tries_next_s = tries_r + TRY_W'(1);
                end
            end
            ST_READY: begin
                if (spawn_req || pending_r) begin
                    piece_type_next_s = next_type_r;
                    float_next_s      = spawn_mask(next_type_r);
                    pos_x_next_s      = 4'(SPAWN_X);
                    pos_y_next_s      = 5'(SPAWN_Y);
                    pending_next_s    = 1'b0;
                    state_next_s      = ST_EMIT;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_EMIT: begin
                pending_next_s = pending_r | spawn_req;
                tries_next_s   = '0;
                state_next_s   = ST_DRAW;
            end
            default: begin
                tries_next_s = '0;
                state_next_s = ST_DRAW;
            end
        endcase
    end

    // State and registered outputs; ready/valid decode the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_DRAW;
            tries_r       <= '0;
            pending_r     <= 1'b0;
            next_type_r   <= 3'd0;
            piece_type_r  <= 3'd0;
            float_r       <= 16'h0000;
            pos_x_r       <= 4'd0;
            pos_y_r       <= 5'd0;
            spawn_valid_r <= 1'b0;
            ready_r       <= 1'b0;
`ifdef PIECE_BAG_EN
            used_r        <= 7'd0;
`endif
        end else begin
            state_r       <= state_next_s;
            tries_r       <= tries_next_s;
            pending_r     <= pending_next_s;
            next_type_r   <= next_type_next_s;
            piece_type_r  <= piece_type_next_s;
            float_r       <= float_next_s;
            pos_x_r       <= pos_x_next_s;
            pos_y_r       <= pos_y_next_s;
            spawn_valid_r <= (state_next_s == ST_EMIT);
            ready_r       <= (state_next_s == ST_READY);
`ifdef PIECE_BAG_EN
            used_r        <= used_next_s;
`endif
        end
    end

    assign spawn_valid = spawn_valid_r;
    assign float       = float_r;
    assign pos_x       = pos_x_r;
    assign pos_y       = pos_y_r;
    assign piece_type  = piece_type_r;
    assign next_type   = next_type_r;
    assign ready       = ready_r;

endmodule
